// File: rtl/sha_1_padder_pkg.sv
// Shared types, constants and byte-lane helpers for the SHA-1 message padder.
package sha_1_padder_pkg;

    localparam int unsigned BLOCK_WORDS  = 16;
    localparam int unsigned BLOCK_BYTES  = 64;
    localparam int unsigned LEN_BYTE_POS = 56;
    localparam logic [7:0]  PAD_BYTE     = 8'h80;
    localparam int unsigned PTR_W        = 7;   // 0..64 inclusive
    localparam int unsigned POS_W        = 6;   // byte index within a block

    // Word 0 is W0; the first byte of each word sits in [31:24].
    typedef logic [BLOCK_WORDS-1:0][31:0] block_t;
    // Byte view of the same 512 bits. Element e covers bits [8e+7:8e].
    typedef logic [BLOCK_BYTES-1:0][7:0]  block_bytes_t;

    typedef enum logic [2:0] {
        ST_ACCEPT     = 3'd0,
        ST_PAD        = 3'd1,
        ST_LEN        = 3'd2,
        ST_EMIT_FULL  = 3'd3,
        ST_EMIT_FINAL = 3'd4
    } state_e;

    // Message byte k lands in word k/4 at lane 3-(k%4), which is element k^3 of the byte view.
    function automatic logic [POS_W-1:0] lane_index(input logic [POS_W-1:0] pos);
        return pos ^ POS_W'(3);
    endfunction

    // Byte-lane write decoder: store one message byte at position pos.
    function automatic block_t put_byte(input block_t blk, input logic [POS_W-1:0] pos,
                                        input logic [7:0] val);
        block_bytes_t bytes;
        bytes = blk;
        bytes[lane_index(pos)] = val;
        return bytes;
    endfunction

    // Place the pad marker at pos and clear every byte after it.
    function automatic block_t pad_tail(input block_t blk, input logic [POS_W-1:0] pos);
        block_bytes_t bytes;
        bytes = blk;
        for (int k = 0; k < BLOCK_BYTES; k++) begin
            if (POS_W'(k) > pos) begin
                bytes[lane_index(POS_W'(k))] = 8'h00;
            end
        end
        bytes[lane_index(pos)] = PAD_BYTE;
        return bytes;
    endfunction

    // Big-endian 64-bit message bit length into bytes 56..63 (words 14 and 15).
    function automatic block_t put_len(input block_t blk, input logic [63:0] len);
        block_t b;
        b = blk;
        b[BLOCK_WORDS-2] = len[63:32];
        b[BLOCK_WORDS-1] = len[31:0];
        return b;
    endfunction

endpackage

// File: rtl/sha_1_padder.sv
// SHA-1 front end: packs a byte stream into 512-bit blocks and appends the padding.
module sha_1_padder
    import sha_1_padder_pkg::*;
#(
    parameter int unsigned LEN_W = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_byte,
    input  logic        in_keep,
    input  logic        in_last,
    output logic        blk_valid,
    input  logic        blk_ready,
    output block_t      blk_data,
    output logic        blk_last,
    output logic        busy
);

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    block_t             buf_q, buf_d;
    logic               pad_pend_q, pad_pend_d;
    logic               len_pend_q, len_pend_d;
    logic               in_ready_q, in_ready_d;
    logic               blk_valid_q, blk_valid_d;
    logic               blk_last_q, blk_last_d;
    logic               busy_q, busy_d;
    logic [63:0]        len64;

    assign len64 = 64'(len_q);

    // Next-state, buffer update and registered-output decode.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        len_d      = len_q;
        buf_d      = buf_q;
        pad_pend_d = pad_pend_q;
        len_pend_d = len_pend_q;

        case (state_q)
            ST_ACCEPT: begin
                if (in_valid && in_ready_q) begin
                    if (in_keep) begin
                        buf_d = put_byte(buf_q, ptr_q[POS_W-1:0], in_byte);
                        ptr_d = ptr_q + PTR_W'(1);
                        len_d = len_q + LEN_W'(8);
                    end
                    // A beat with keep=0 and last=0 is dropped without effect.
                    if (in_keep && (ptr_q == PTR_W'(BLOCK_BYTES - 1))) begin
                        state_d    = ST_EMIT_FULL;
                        pad_pend_d = in_last;
                    end else if (in_last) begin
                        state_d = ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                buf_d = pad_tail(buf_q, ptr_q[POS_W-1:0]);
                if (ptr_q <= PTR_W'(LEN_BYTE_POS - 1)) begin
                    buf_d   = put_len(buf_d, len64);
                    state_d = ST_EMIT_FINAL;
                end else begin
                    len_pend_d = 1'b1;
                    state_d    = ST_EMIT_FULL;
                end
            end
            ST_LEN: begin
                buf_d      = put_len('0, len64);
                len_pend_d = 1'b0;
                state_d    = ST_EMIT_FINAL;
            end
            ST_EMIT_FULL: begin
                if (blk_valid_q && blk_ready) begin
                    buf_d = '0;
                    ptr_d = '0;
                    if (pad_pend_q) begin
                        pad_pend_d = 1'b0;
                        state_d    = ST_PAD;
                    end else if (len_pend_q) begin
                        state_d = ST_LEN;
                    end else begin
                        state_d = ST_ACCEPT;
                    end
                end
            end
            ST_EMIT_FINAL: begin
                if (blk_valid_q && blk_ready) begin
                    buf_d   = '0;
                    ptr_d   = '0;
                    len_d   = '0;
                    state_d = ST_ACCEPT;
                end
            end
            default: begin
                state_d = ST_ACCEPT;
            end
        endcase

        in_ready_d  = (state_d == ST_ACCEPT);
        blk_valid_d = (state_d == ST_EMIT_FULL) || (state_d == ST_EMIT_FINAL);
        blk_last_d  = (state_d == ST_EMIT_FINAL);
        busy_d      = !((state_d == ST_ACCEPT) && (ptr_d == '0));
    end

    // State and output registers; reset discards any partial message.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACCEPT;
            ptr_q       <= '0;
            len_q       <= '0;
            buf_q       <= '0;
            pad_pend_q  <= 1'b0;
            len_pend_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            blk_valid_q <= 1'b0;
            blk_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            len_q       <= len_d;
            buf_q       <= buf_d;
            pad_pend_q  <= pad_pend_d;
            len_pend_q  <= len_pend_d;
            in_ready_q  <= in_ready_d;
            blk_valid_q <= blk_valid_d;
            blk_last_q  <= blk_last_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign blk_valid = blk_valid_q;
    assign blk_last  = blk_last_q;
    assign busy      = busy_q;
    assign blk_data  = buf_q;

    // keep=0 is only meaningful as the empty-message marker on the last beat.
    keep_needs_last: assert property (@(posedge clk) disable iff (!rst_n)
        (in_valid && in_ready && !in_keep) |-> in_last);

endmodule

// File: tb/tb_sha_1_padder.sv
// Self-checking bench for sha_1_padder against a queue-based SHA-1 padding model.
module tb_sha_1_padder;
    import sha_1_padder_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_byte = 8'h00;
    logic       in_keep = 1'b0;
    logic       in_last = 1'b0;
    logic       blk_valid;
    logic       blk_ready = 1'b0;
    block_t     blk_data;
    logic       blk_last;
    logic       busy;

    int total = 0;
    int bad = 0;

    block_t exp_data[$];
    bit     exp_last[$];
    block_t got_data[$];
    bit     got_last[$];

    always #5 clk = ~clk;

    sha_1_padder #(.LEN_W(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_byte   (in_byte),
        .in_keep   (in_keep),
        .in_last   (in_last),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_last  (blk_last),
        .busy      (busy)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: message + 0x80 + zeros to 56 mod 64 + 64-bit big-endian bit length, cut into words.
    function automatic void model(input logic [7:0] msg[$]);
        logic [7:0]  pad[$];
        logic [63:0] bitlen;
        int          nblk;
        exp_data.delete();
        exp_last.delete();
        pad = msg;
        pad.push_back(8'h80);
        while ((pad.size() % 64) != 56) pad.push_back(8'h00);
        bitlen = 64'(msg.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) pad.push_back(8'(bitlen >> (8 * i)));
        nblk = pad.size() / 64;
        for (int b = 0; b < nblk; b++) begin
            block_t blk;
            for (int w = 0; w < 16; w++) begin
                blk[w] = {pad[b*64 + 4*w], pad[b*64 + 4*w + 1],
                          pad[b*64 + 4*w + 2], pad[b*64 + 4*w + 3]};
            end
            exp_data.push_back(blk);
            exp_last.push_back(b == nblk - 1);
        end
    endfunction

    // Byte-stream driver; an empty message is a single keep=0/last=1 beat.
    task automatic send_msg(input logic [7:0] msg[$], input bit with_last, input int gap_pct);
        int n = msg.size();
        int beats = (n == 0) ? 1 : n;
        int idx = 0;
        int budget = 0;
        while (idx < beats && budget < 5000) begin
            @(negedge clk);
            budget++;
            if (int'($urandom_range(99, 0)) < gap_pct) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_keep  = (n != 0);
                in_byte  = (n != 0) ? msg[idx] : 8'h00;
                in_last  = with_last && (idx == beats - 1);
                if (in_ready) idx++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_keep  = 1'b0;
        in_last  = 1'b0;
        total++;
        if (idx < beats) begin
            bad++;
            $display("FAIL send_timeout: beats accepted %0d, wanted %0d", idx, beats);
        end
    endtask

    // Block sink with random back-pressure; also watches hold-stability while stalled.
    task automatic collect(input int ready_pct);
        int     budget = 0;
        bit     done = 1'b0;
        bit     stalled = 1'b0;
        block_t prev = '0;
        got_data.delete();
        got_last.delete();
        while (!done && budget < 5000) begin
            @(negedge clk);
            budget++;
            if (stalled) begin
                total++;
                if (blk_valid !== 1'b1 || blk_data !== prev) begin
                    bad++;
                    $display("FAIL hold_stable: valid=%b data=%h, wanted valid=1 data=%h",
                             blk_valid, blk_data, prev);
                end
            end
            blk_ready = (int'($urandom_range(99, 0)) < ready_pct);
            stalled   = blk_valid && !blk_ready;
            prev      = blk_data;
            if (blk_valid && blk_ready) begin
                got_data.push_back(blk_data);
                got_last.push_back(blk_last);
                if (blk_last) done = 1'b1;
            end
        end
        @(negedge clk);
        blk_ready = 1'b0;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL collect_timeout: blocks seen %0d, final block never arrived", got_data.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (blk_valid !== 1'b0 || blk_last !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: valid=%b last=%b busy=%b ready=%b, wanted all 0",
                     blk_valid, blk_last, busy, in_ready);
        end
        total++;
        if (blk_data !== '0) begin
            bad++;
            $display("FAIL reset_data: got %h, wanted 0", blk_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_ready: ready=%b busy=%b, wanted ready=1 busy=0", in_ready, busy);
        end
    endtask

    task automatic test_abc();
        logic [7:0] abc[3] = '{8'h61, 8'h62, 8'h63};
        bit mid_zero = 1'b1;
        blk_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL abc_ready: beat %0d ready=%b, wanted 1", i, in_ready);
            end
            in_valid = 1'b1;
            in_keep  = 1'b1;
            in_byte  = abc[i];
            in_last  = (i == 2);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        total++;
        if (blk_valid !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL abc_pad_cycle: valid=%b ready=%b, wanted 0 0", blk_valid, in_ready);
        end
        @(negedge clk);
        total++;
        if (blk_valid !== 1'b1 || blk_last !== 1'b1) begin
            bad++;
            $display("FAIL abc_latency: valid=%b last=%b two cycles after last byte, wanted 1 1",
                     blk_valid, blk_last);
        end
        for (int w = 1; w < 15; w++) if (blk_data[w] !== 32'h0) mid_zero = 1'b0;
        total++;
        if (blk_data[0] !== 32'h61626380 || blk_data[15] !== 32'h00000018 ||
            blk_data[14] !== 32'h0 || !mid_zero) begin
            bad++;
            $display("FAIL abc_block: got %h, wanted w0=61626380 w15=00000018 rest 0", blk_data);
        end
        @(negedge clk);
        blk_ready = 1'b0;
        total++;
        if (blk_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL abc_done: valid=%b busy=%b ready=%b, wanted 0 0 1", blk_valid, busy, in_ready);
        end
    endtask

    task automatic test_empty();
        logic [7:0] msg[$];
        bit rest_zero = 1'b1;
        model(msg);
        fork
            send_msg(msg, 1'b1, 0);
            collect(100);
        join
        for (int w = 1; w < 16; w++) if (got_data.size() > 0 && got_data[0][w] !== 32'h0) rest_zero = 1'b0;
        total++;
        if (got_data.size() != 1 || got_data[0][0] !== 32'h80000000 || !rest_zero || got_last[0] !== 1'b1) begin
            bad++;
            $display("FAIL empty_msg: blocks=%0d data=%h, wanted one block w0=80000000 rest 0",
                     got_data.size(), (got_data.size() > 0) ? got_data[0] : '0);
        end
    endtask

    // Fixed lengths straddling the length-field and block boundaries.
    task automatic test_lengths();
        int lens[6] = '{55, 56, 63, 64, 119, 120};
        logic [7:0] msg[$];
        for (int t = 0; t < 6; t++) begin
            msg.delete();
            for (int i = 0; i < lens[t]; i++) msg.push_back(8'h41);
            model(msg);
            fork
                send_msg(msg, 1'b1, 20);
                collect(70);
            join
            total++;
            if (got_data.size() != exp_data.size()) begin
                bad++;
                $display("FAIL len%0d_count: got %0d blocks, wanted %0d", lens[t], got_data.size(), exp_data.size());
            end else begin
                for (int b = 0; b < exp_data.size(); b++) begin
                    total++;
                    if (got_data[b] !== exp_data[b] || got_last[b] !== exp_last[b]) begin
                        bad++;
                        $display("FAIL len%0d_blk%0d: got last=%b %h, wanted last=%b %h", lens[t], b,
                                 got_last[b], got_data[b], exp_last[b], exp_data[b]);
                    end
                end
            end
        end
        total++;
        if (lens[0] == 55 && exp_data.size() == 3 && exp_data[2][15] !== 32'h000003C0) begin
            bad++;
            $display("FAIL model_len120: word15 %h, wanted 000003C0", exp_data[2][15]);
        end
    endtask

    task automatic test_stall();
        logic [7:0] msg[$];
        block_t first = '0;
        int     budget = 0;
        for (int i = 0; i < 64; i++) msg.push_back(8'($urandom));
        model(msg);
        blk_ready = 1'b0;
        fork
            send_msg(msg, 1'b1, 0);
            begin
                while (!blk_valid && budget < 500) begin
                    @(negedge clk);
                    budget++;
                end
                first = blk_data;
                total++;
                if (first !== exp_data[0] || blk_last !== 1'b0) begin
                    bad++;
                    $display("FAIL stall_blk0: got last=%b %h, wanted last=0 %h", blk_last, first, exp_data[0]);
                end
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    total++;
                    if (blk_valid !== 1'b1 || blk_data !== first || in_ready !== 1'b0) begin
                        bad++;
                        $display("FAIL stall_hold c%0d: valid=%b ready=%b data=%h, wanted 1 0 %h",
                                 c, blk_valid, in_ready, blk_data, first);
                    end
                end
                blk_ready = 1'b1;
                @(negedge clk);
                blk_ready = 1'b0;
            end
        join
        collect(100);
        total++;
        if (got_data.size() != 1 || got_data[0] !== exp_data[1] || got_data[0][0] !== 32'h80000000 ||
            got_data[0][15] !== 32'h00000200 || got_last[0] !== 1'b1) begin
            bad++;
            $display("FAIL stall_blk1: blocks=%0d data=%h, wanted one final block %h",
                     got_data.size(), (got_data.size() > 0) ? got_data[0] : '0, exp_data[1]);
        end
    endtask

    task automatic test_abort();
        logic [7:0] part[$];
        logic [7:0] abc[$];
        bit seen_valid = 1'b0;
        for (int i = 0; i < 30; i++) part.push_back(8'($urandom));
        send_msg(part, 1'b0, 0);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL abort_busy: busy=%b mid-message, wanted 1", busy);
        end
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (blk_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || blk_data !== '0) begin
            bad++;
            $display("FAIL abort_reset: valid=%b busy=%b ready=%b data=%h, wanted all 0",
                     blk_valid, busy, in_ready, blk_data);
        end
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (blk_valid) seen_valid = 1'b1;
        end
        total++;
        if (seen_valid) begin
            bad++;
            $display("FAIL abort_no_block: blk_valid seen=1 after abort, wanted 0");
        end
        abc = '{8'h61, 8'h62, 8'h63};
        model(abc);
        fork
            send_msg(abc, 1'b1, 0);
            collect(100);
        join
        total++;
        if (got_data.size() != 1 || got_data[0] !== exp_data[0] || got_last[0] !== 1'b1) begin
            bad++;
            $display("FAIL abort_abc: blocks=%0d data=%h, wanted %h",
                     got_data.size(), (got_data.size() > 0) ? got_data[0] : '0, exp_data[0]);
        end
    endtask

    task automatic test_random();
        logic [7:0] msg[$];
        int n;
        for (int t = 0; t < 12; t++) begin
            msg.delete();
            n = int'($urandom_range(140, 0));
            for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
            model(msg);
            fork
                send_msg(msg, 1'b1, 30);
                collect(60);
            join
            total++;
            if (got_data.size() != exp_data.size()) begin
                bad++;
                $display("FAIL rand%0d_count: len=%0d got %0d blocks, wanted %0d", t, n,
                         got_data.size(), exp_data.size());
            end else begin
                for (int b = 0; b < exp_data.size(); b++) begin
                    total++;
                    if (got_data[b] !== exp_data[b] || got_last[b] !== exp_last[b]) begin
                        bad++;
                        $display("FAIL rand%0d_blk%0d: len=%0d got last=%b %h, wanted last=%b %h", t, b, n,
                                 got_last[b], got_data[b], exp_last[b], exp_data[b]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_abc();
        test_empty();
        test_lengths();
        test_stall();
        test_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
